// File: rtl/mem_result_checker.sv
// Memory result checker: polls a completion word, then compares a window of
// memory against a golden stream under a periodic mask, with a watchdog.
module mem_result_checker #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 12,
  parameter int TMO_W  = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] end_code,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [TMO_W-1:0]  timeout_cycles,
  input  logic [DATA_W-1:0] mask_norm,
  input  logic [DATA_W-1:0] mask_alt,
  input  logic [CNT_W-1:0]  alt_period,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              gold_valid,
  input  logic [DATA_W-1:0] gold_data,
  output logic              gold_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_got,
  output logic [DATA_W-1:0] err_exp
);

  typedef enum logic [2:0] {
    IDLE, POLL_REQ, POLL_WAIT, SCAN_REQ, SCAN_WAIT, SCAN_CMP, DONE
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] end_addr_reg, base_addr_reg;
  logic [DATA_W-1:0] end_code_reg, mask_norm_reg, mask_alt_reg;
  logic [CNT_W-1:0]  num_words_reg, alt_period_reg;
  logic [TMO_W-1:0]  tmo_reg, wd_cnt_reg;
  logic [CNT_W-1:0]  idx_reg, alt_cnt_reg;
  logic [DATA_W-1:0] got_reg;

  logic              in_poll, in_scan, start_ok, wd_fire, alt_hit, mismatch;
  logic              cmp_fire, last_word;
  logic [DATA_W-1:0] cmp_mask;
  logic [ADDR_W-1:0] scan_addr;
  logic [CNT_W-1:0]  idx_inc;
  state_t            dump_state;

  assign in_poll   = (state_reg == POLL_REQ) || (state_reg == POLL_WAIT);
  assign in_scan   = (state_reg == SCAN_REQ) || (state_reg == SCAN_WAIT) || (state_reg == SCAN_CMP);
  assign busy      = in_poll || in_scan;
  assign done      = (state_reg == DONE);
  assign pass      = done && (err_count == '0) && !timeout;
  assign start_ok  = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign wd_fire   = busy && (tmo_reg != '0) && (wd_cnt_reg == tmo_reg);

  // alt_cnt_reg tracks idx % alt_period incrementally, avoiding a divider
  assign alt_hit   = (alt_period_reg != '0) && (alt_cnt_reg == alt_period_reg - CNT_W'(1));
  assign cmp_mask  = alt_hit ? mask_alt_reg : mask_norm_reg;
  assign mismatch  = ((got_reg ^ gold_data) & cmp_mask) != '0;
  assign scan_addr = base_addr_reg + ADDR_W'(idx_reg);
  assign idx_inc   = idx_reg + CNT_W'(1);
  assign last_word = (idx_inc == num_words_reg);
  // With nothing to scan, a poll timeout finishes the run instead of dumping
  assign dump_state = (num_words_reg == '0) ? DONE : SCAN_REQ;

  assign rd_req  = (state_reg == POLL_REQ) || (state_reg == SCAN_REQ);
  assign rd_addr = (state_reg == POLL_REQ) ? end_addr_reg :
                   (state_reg == SCAN_REQ) ? scan_addr : '0;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    gold_ready = 1'b0;
    cmp_fire   = 1'b0;
    case (state_reg)
      IDLE, DONE: if (start) state_next = POLL_REQ;
      POLL_REQ: begin
        if (wd_fire)     state_next = dump_state;
        else if (rd_gnt) state_next = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (wd_fire) state_next = dump_state;
        else if (rd_valid) begin
          if (rd_data == end_code_reg) state_next = (num_words_reg == '0) ? DONE : SCAN_REQ;
          else                         state_next = POLL_REQ;
        end
      end
      SCAN_REQ: begin
        if (wd_fire)     state_next = DONE;
        else if (rd_gnt) state_next = SCAN_WAIT;
      end
      SCAN_WAIT: begin
        if (wd_fire)       state_next = DONE;
        else if (rd_valid) state_next = SCAN_CMP;
      end
      SCAN_CMP: begin
        if (wd_fire) state_next = DONE;
        else if (gold_valid) begin
          gold_ready = 1'b1;
          cmp_fire   = 1'b1;
          state_next = last_word ? DONE : SCAN_REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      end_addr_reg   <= '0;
      base_addr_reg  <= '0;
      end_code_reg   <= '0;
      mask_norm_reg  <= '0;
      mask_alt_reg   <= '0;
      num_words_reg  <= '0;
      alt_period_reg <= '0;
      tmo_reg        <= '0;
      wd_cnt_reg     <= '0;
      idx_reg        <= '0;
      alt_cnt_reg    <= '0;
      got_reg        <= '0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_idx  <= '1;
      err_valid      <= 1'b0;
      err_addr       <= '0;
      err_got        <= '0;
      err_exp        <= '0;
    end else begin
      err_valid <= 1'b0;
      if (start_ok) begin
        end_addr_reg   <= end_addr;
        base_addr_reg  <= base_addr;
        end_code_reg   <= end_code;
        mask_norm_reg  <= mask_norm;
        mask_alt_reg   <= mask_alt;
        num_words_reg  <= num_words;
        alt_period_reg <= alt_period;
        tmo_reg        <= timeout_cycles;
        wd_cnt_reg     <= '0;
        idx_reg        <= '0;
        alt_cnt_reg    <= '0;
        timeout        <= 1'b0;
        err_count      <= '0;
        first_err_idx  <= '1;
      end else begin
        if (busy && (tmo_reg != '0))
          wd_cnt_reg <= wd_fire ? '0 : wd_cnt_reg + TMO_W'(1);
        if (wd_fire)
          timeout <= 1'b1;
        if ((state_reg == SCAN_WAIT) && rd_valid)
          got_reg <= rd_data;
        if (cmp_fire) begin
          idx_reg     <= idx_inc;
          alt_cnt_reg <= alt_hit ? '0 : alt_cnt_reg + CNT_W'(1);
          if (mismatch) begin
            err_valid <= 1'b1;
            err_addr  <= scan_addr;
            err_got   <= got_reg;
            err_exp   <= gold_data;
            if (err_count != '1)     err_count     <= err_count + CNT_W'(1);
            if (first_err_idx == '1) first_err_idx <= idx_reg;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_result_checker.sv
// Directed bench for mem_result_checker with a negedge-driven memory/golden model.
module tb_mem_result_checker;
  localparam int ADDR_W = 32, DATA_W = 32, CNT_W = 12, TMO_W = 32;
  localparam logic [31:0] END_ADDR = 32'h0000_0080;
  localparam logic [31:0] BASE     = 32'h0000_0100;
  localparam logic [31:0] END_CODE = 32'hFFFF_FFFF;

  logic              cpu_clk = 1'b0;
  logic              cpu_rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] end_addr = END_ADDR;
  logic [DATA_W-1:0] end_code = END_CODE;
  logic [ADDR_W-1:0] base_addr = BASE;
  logic [CNT_W-1:0]  num_words = '0;
  logic [TMO_W-1:0]  timeout_cycles = '0;
  logic [DATA_W-1:0] mask_norm = 32'hFFFF_FFFF;
  logic [DATA_W-1:0] mask_alt = 32'hFFFF_FFFF;
  logic [CNT_W-1:0]  alt_period = '0;
  logic              rd_req, rd_gnt = 1'b0, rd_valid = 1'b0, gold_valid = 1'b0, gold_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data = '0, gold_data = '0;
  logic              busy, done, pass, timeout, err_valid;
  logic [CNT_W-1:0]  err_count, first_err_idx;
  logic [ADDR_W-1:0] err_addr;
  logic [DATA_W-1:0] err_got, err_exp;

  mem_result_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .start(start), .end_addr(end_addr),
    .end_code(end_code), .base_addr(base_addr), .num_words(num_words),
    .timeout_cycles(timeout_cycles), .mask_norm(mask_norm), .mask_alt(mask_alt),
    .alt_period(alt_period), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .gold_valid(gold_valid),
    .gold_data(gold_data), .gold_ready(gold_ready), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_count(err_count),
    .first_err_idx(first_err_idx), .err_valid(err_valid), .err_addr(err_addr),
    .err_got(err_got), .err_exp(err_exp)
  );

  always #5 cpu_clk = ~cpu_clk;

  logic [31:0] mem [16];
  logic [31:0] gold [16];
  int  poll_cnt, poll_target, gptr, pulses, scan_grants;
  int  gnt_gap, gold_gap, wait_cnt, gwait = 100;
  bit  gnt_pend, take_pend, req_held, addr_bad;
  logic [31:0] pend_addr, held_addr;
  int  n_checks = 0, n_errs = 0;
  int  cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Memory/golden model: decisions at negedge, handshakes sampled 1 time unit later
  always begin
    @(negedge cpu_clk);
    if (cpu_rst) begin
      rd_gnt = 1'b0; rd_valid = 1'b0; gnt_pend = 1'b0; take_pend = 1'b0;
      req_held = 1'b0; wait_cnt = 0;
    end else begin
      rd_valid = 1'b0;
      if (gnt_pend) begin
        rd_valid = 1'b1;
        if (pend_addr == END_ADDR) begin
          poll_cnt++;
          rd_data = (poll_cnt >= poll_target) ? END_CODE : 32'h0;
        end else begin
          rd_data = mem[pend_addr[3:0]];
        end
        gwait = 0;
      end
      if (take_pend) gptr++;
      if (err_valid) pulses++;
      rd_gnt = 1'b0;
      if (rd_req) begin
        if (req_held && (rd_addr != held_addr)) addr_bad = 1'b1;
        if (wait_cnt < gnt_gap) begin
          wait_cnt++; req_held = 1'b1; held_addr = rd_addr;
        end else begin
          rd_gnt = 1'b1; wait_cnt = 0; req_held = 1'b0;
        end
      end else begin
        req_held = 1'b0; wait_cnt = 0;
      end
      gold_valid = (gwait >= gold_gap);
      gold_data  = gold[gptr % 16];
      if (gwait < gold_gap) gwait++;
      #1;
      gnt_pend  = rd_req && rd_gnt;
      pend_addr = rd_addr;
      if (gnt_pend && (rd_addr != END_ADDR)) scan_grants++;
      take_pend = gold_valid && gold_ready;
    end
  end

  task automatic init_data();
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 32'hC0DE_0000 + i;
      gold[i] = 32'hC0DE_0000 + i;
    end
  endtask

  task automatic go(input int ptarget, input int tmo, input int nwords, input int aperiod,
                    input logic [31:0] malt, input int ggap, input int dgap);
    poll_target = ptarget; timeout_cycles = tmo; num_words = nwords[CNT_W-1:0];
    alt_period = aperiod[CNT_W-1:0]; mask_alt = malt;
    gold_gap = ggap; gnt_gap = dgap;
    poll_cnt = 0; gptr = 0; pulses = 0; scan_grants = 0; addr_bad = 1'b0;
    @(negedge cpu_clk); start = 1'b1;
    @(negedge cpu_clk); start = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 5000) begin
      @(negedge cpu_clk);
      c++;
    end
    check("done_reached", done, 1);
    @(negedge cpu_clk); #2;
  endtask

  task automatic report(input string name);
    $display("run %s: done=%0b pass=%0b timeout=%0b err_count=%0d first_err_idx=%0h pulses=%0d golden=%0d",
             name, done, pass, timeout, err_count, first_err_idx, pulses, gptr);
  endtask

  initial begin
    init_data();
    repeat (4) @(negedge cpu_clk);
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_pass", pass, 0);
    check("rst_timeout", timeout, 0);
    check("rst_err_count", err_count, 0);
    check("rst_first_err", first_err_idx, 12'hFFF);
    check("rst_rd_req", rd_req, 0);

    // Happy path: completion after 10 polls, 8 matching words
    go(10, 0, 8, 0, 32'hFFFF_FFFF, 0, 0);
    check("happy_req_after_start", rd_req, 1);
    check("happy_rd_addr_poll", rd_addr, END_ADDR);
    wait_done(cyc);
    report("happy");
    check("happy_cycles", cyc, 44);
    check("happy_polls", poll_cnt, 10);
    check("happy_pass", pass, 1);
    check("happy_err_count", err_count, 0);
    check("happy_first_err", first_err_idx, 12'hFFF);
    check("happy_golden", gptr, 8);

    // Single mismatch at word 3
    mem[3] = 32'h0000_0012; gold[3] = 32'h0000_0013;
    go(10, 0, 8, 0, 32'hFFFF_FFFF, 0, 0);
    wait_done(cyc);
    report("mismatch");
    check("mm_pulses", pulses, 1);
    check("mm_err_addr", err_addr, BASE + 3);
    check("mm_err_got", err_got, 32'h0000_0012);
    check("mm_err_exp", err_exp, 32'h0000_0013);
    check("mm_err_count", err_count, 1);
    check("mm_first_err", first_err_idx, 3);
    check("mm_pass", pass, 0);

    // Back-pressure on grant and golden stream, same data as above
    go(10, 0, 8, 0, 32'hFFFF_FFFF, 3, 5);
    wait_done(cyc);
    report("backpressure");
    check("bp_addr_stable", addr_bad, 0);
    check("bp_golden", gptr, 8);
    check("bp_pulses", pulses, 1);
    check("bp_err_addr", err_addr, BASE + 3);
    check("bp_err_count", err_count, 1);
    check("bp_first_err", first_err_idx, 3);

    // Alt mask: word 3 masked to low byte, word 2 fully compared
    init_data();
    mem[3] = 32'hAB00_0042; gold[3] = 32'h0000_0042;
    mem[2] = 32'hAB00_0042; gold[2] = 32'h0000_0042;
    go(1, 0, 8, 4, 32'h0000_00FF, 0, 0);
    wait_done(cyc);
    report("alt_mask");
    check("alt_err_count", err_count, 1);
    check("alt_first_err", first_err_idx, 2);
    check("alt_err_addr", err_addr, BASE + 2);
    check("alt_pulses", pulses, 1);

    // Timeout: completion never arrives, dump scan still runs
    init_data();
    go(1000000, 100, 8, 0, 32'hFFFF_FFFF, 0, 0);
    cyc = 0;
    while (!timeout && cyc < 1000) begin
      @(negedge cpu_clk);
      cyc++;
    end
    check("tmo_cycle", cyc, 101);
    check("tmo_busy", busy, 1);
    wait_done(cyc);
    report("timeout");
    check("tmo_flag", timeout, 1);
    check("tmo_pass", pass, 0);
    check("tmo_err_count", err_count, 0);
    check("tmo_golden", gptr, 8);

    // Reset while waiting for a scan read, then an empty run
    mem[0] = 32'h0;
    go(1, 0, 8, 0, 32'hFFFF_FFFF, 0, 0);
    cyc = 0;
    while (scan_grants < 3 && cyc < 1000) begin
      @(posedge cpu_clk); #2;
      cyc++;
    end
    check("rstmid_reached", scan_grants, 3);
    check("rstmid_err_before", err_count, 1);
    cpu_rst = 1'b1;
    @(posedge cpu_clk); #2;
    cpu_rst = 1'b0;
    @(negedge cpu_clk);
    report("reset_mid_scan");
    check("rstmid_busy", busy, 0);
    check("rstmid_err_count", err_count, 0);
    check("rstmid_first_err", first_err_idx, 12'hFFF);
    check("rstmid_err_valid", err_valid, 0);
    go(1, 0, 0, 0, 32'hFFFF_FFFF, 0, 0);
    wait_done(cyc);
    report("empty");
    check("empty_cycles", cyc, 2);
    check("empty_pass", pass, 1);
    check("empty_err_count", err_count, 0);
    check("empty_first_err", first_err_idx, 12'hFFF);
    check("empty_golden", gptr, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_result_checker.md
# mem_result_checker

Hardware result checker used in the chip-level bench and in DLA self-test builds. On `start` it polls a completion word until it matches an end code. It then scans a window of memory words and compares each against a golden word stream under a configurable mask. It reports an error count, the first failing index, per-mismatch detail and a timeout flag. It generalises the polling and golden-compare flow to parametrised widths and depth, periodic truncation masks, a watchdog with dump-on-timeout, and a handshaked memory read port.

## Interface
Parameters:
- `ADDR_W`, 32, word-address width of the read port
- `DATA_W`, 32, data width of memory and golden words
- `CNT_W`, 12, width of word count and indices (max 4095 words)
- `TMO_W`, 32, watchdog counter width

Ports:
- `cpu_clk`  in  1  clock; only clock
- `cpu_rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle pulse, sampled only in IDLE or DONE
- `end_addr`  in  ADDR_W  completion word address
- `end_code`  in  DATA_W  completion value (e.g. 32'hFFFF_FFFF)
- `base_addr`  in  ADDR_W  first scanned word address
- `num_words`  in  CNT_W  words to compare
- `timeout_cycles`  in  TMO_W  watchdog limit; 0 = disabled
- `mask_norm`  in  DATA_W  compare mask for ordinary words
- `mask_alt`  in  DATA_W  compare mask for every `alt_period`-th word
- `alt_period`  in  CNT_W  0 = alt mask unused
- `rd_req`  out  1  read request
- `rd_addr`  out  ADDR_W  read word address
- `rd_gnt`  in  1  request accepted
- `rd_valid`  in  1  read data valid
- `rd_data`  in  DATA_W  read data
- `gold_valid`  in  1  golden word available
- `gold_data`  in  DATA_W  golden word
- `gold_ready`  out  1  golden word consumed this cycle
- `busy`  out  1  not in IDLE/DONE
- `done`  out  1  held high in DONE
- `pass`  out  1  valid with `done`
- `timeout`  out  1  watchdog fired during current run
- `err_count`  out  CNT_W  mismatches, saturating at all-ones
- `first_err_idx`  out  CNT_W  index of first mismatch; all-ones if none
- `err_valid`  out  1  one-cycle pulse per mismatch
- `err_addr`, `err_got`, `err_exp`  out  ADDR_W/DATA_W/DATA_W  mismatch detail, valid with `err_valid`, held after

## Operation
- States: IDLE, POLL_REQ, POLL_WAIT, SCAN_REQ, SCAN_WAIT, SCAN_CMP, DONE.
- `start` latches all configuration inputs, clears counters, flags and `idx`, and goes to POLL_REQ.
- POLL_REQ: assert `rd_req` with `rd_addr=end_addr`; hold both stable until `rd_gnt`; then go to POLL_WAIT.
- POLL_WAIT: on `rd_valid`, if `rd_data==end_code` go to SCAN_REQ (or DONE if `num_words==0`); otherwise return to POLL_REQ.
- SCAN_REQ: `rd_addr=base_addr+idx` (wraps modulo 2^ADDR_W); same request rule as POLL_REQ; then go to SCAN_WAIT.
- SCAN_WAIT: on `rd_valid`, capture `rd_data` and go to SCAN_CMP.
- SCAN_CMP: wait for `gold_valid`; assert `gold_ready` in the cycle `gold_valid` is seen.
  - Mask `m` is `mask_alt` when `alt_period!=0` and `idx % alt_period == alt_period-1`; otherwise `mask_norm`.
  - A mismatch is `(got & m) != (gold_data & m)`. On mismatch: pulse `err_valid`, load detail registers, increment `err_count` with saturation, and set `first_err_idx` if it is unset.
  - Then `idx++`; if `idx==num_words` go to DONE, else go to SCAN_REQ.
- DONE: `pass = (err_count==0) && !timeout`.
- Watchdog: a cycle counter runs in all busy states while `timeout_cycles!=0`. When it reaches `timeout_cycles`, set `timeout`.
  - If in a POLL state: abandon polling, clear the counter, and enter SCAN_REQ (dump mode). Any outstanding read is dropped: a `rd_valid` arriving in SCAN_REQ is ignored.
  - If in a SCAN state: go directly to DONE.
- Only one outstanding read is allowed. `rd_valid` outside the WAIT states is ignored.
- `start` while busy is ignored.

## Timing
- Reset: state IDLE; all outputs 0 except `first_err_idx` = all-ones. Reset takes effect in the next cycle from any state, mid-read included; the memory side must tolerate abandoned requests.
- `rd_req` rises the cycle after `start` when `rd_gnt` is tied high. Minimum per-word cost is 3 cycles (REQ, WAIT, CMP), with zero-latency `rd_valid` in the cycle after grant and `gold_valid` tied high.
- `err_valid`, `err_count` and `first_err_idx` update at the clock edge ending the SCAN_CMP cycle. `done` rises the following cycle.
- `gold_ready` is combinational from state and `gold_valid`; at most one golden word is consumed per scanned word.
- The watchdog compare uses the registered count; the timeout transition occurs in the cycle after the count equals the limit.

## Test plan
- Happy path: end word becomes FFFF_FFFF after 10 polls; 8 words match → `done=1`, `pass=1`, `err_count=0`, `first_err_idx=FFF`.
- Mismatch: word 3 reads 0000_0012, golden 0000_0013 → one `err_valid` with `err_addr=base+3`, `err_count=1`, `first_err_idx=3`, `pass=0`.
- Alt mask: `alt_period=4`, `mask_alt=0000_00FF`, word 3 reads AB00_0042 vs golden 0000_0042 → no error; same difference at word 2 → error.
- Timeout: end word never written, `timeout_cycles=100` → at cycle ~101 `timeout=1`, scan of `num_words` still runs, then `done=1`, `pass=0`.
- Back-pressure: `rd_gnt` low for 5 cycles and `gold_valid` low for 3 → `rd_addr` held stable, no skipped or duplicated golden words, result unchanged.
- `cpu_rst` during SCAN_WAIT, then a new `start` with `num_words=0` → outputs return to reset values; `done=1`, `pass=1` directly after the poll matches.
